// File: rtl/cell_array_pkg.sv
// Shared types and constants for the SR-latch cell array access controller.
//   state_e : access sequencer states (idle / setup / active / hold)
//   NUM_REQ : number of requesters served by the round-robin arbiter
//   REQ0/1  : requester indices used for grant bits and response ids
package cell_array_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StActive,
    StHold
  } state_e;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned REQ0    = 0;
  localparam int unsigned REQ1    = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
//   req_i        : request vector, bit i = requester i
//   last_grant_i : index of the requester granted most recently
//   enable_i     : arbitration allowed this cycle; grant is zero otherwise
//   grant_o      : one-hot (or zero) grant vector
module rr_arb2
  import cell_array_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               last_grant_i,
  input  logic               enable_i,
  output logic [NUM_REQ-1:0] grant_o
);

  always_comb begin
    grant_o = '0;
    if (enable_i) begin
      case (req_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        // Contention: favour whoever did not win last time.
        2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
        default: grant_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/cell_array_ctrl.sv
// Access controller for a DEPTH x WIDTH array of SR-latch cells.
// Arbitrates two word requesters and drives the array with a
// setup / select / hold sequence so the latches only see cs while
// address, rd_wr and write data are stable.
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/ready   : per-requester handshake (ready is the arbiter grant)
//   req_we/addr/wdata : per-requester packed request fields
//   rsp_valid/id      : one-cycle completion pulse and owning requester
//   rsp_rdata/err     : read word, out-of-range flag
//   cell_cs           : one-hot row select
//   cell_rd_wr        : shared direction (1 = read)
//   cell_wr_data      : shared column write data
//   cell_rd_data      : OR of all row outputs
module cell_array_ctrl
  import cell_array_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int unsigned PULSE = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ*AW-1:0]      req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]   req_wdata,
  output logic                       rsp_valid,
  output logic                       rsp_id,
  output logic [WIDTH-1:0]           rsp_rdata,
  output logic                       rsp_err,
  output logic [DEPTH-1:0]           cell_cs,
  output logic                       cell_rd_wr,
  output logic [WIDTH-1:0]           cell_wr_data,
  input  logic [WIDTH-1:0]           cell_rd_data
);

  localparam int unsigned CW = (PULSE > 1) ? $clog2(PULSE) : 1;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic              id_q, id_d;
  logic              err_q, err_d;

  logic [DEPTH-1:0]  cell_cs_q, cell_cs_d;
  logic              cell_rd_wr_q, cell_rd_wr_d;
  logic [WIDTH-1:0]  cell_wr_data_q, cell_wr_data_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0] grant;
  logic               accept;
  logic               sel;
  logic               sel_we;
  logic [AW-1:0]      sel_addr;
  logic [WIDTH-1:0]   sel_wdata;
  logic               sel_err;
  logic               last_active;

  rr_arb2 u_arb (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .enable_i     (state_q == StIdle),
    .grant_o      (grant)
  );

  assign req_ready = grant;
  assign accept    = |(req_valid & grant);
  assign sel       = grant[REQ1];
  assign sel_we    = sel ? req_we[REQ1] : req_we[REQ0];
  assign sel_addr  = sel ? req_addr[AW +: AW] : req_addr[0 +: AW];
  assign sel_wdata = sel ? req_wdata[WIDTH +: WIDTH] : req_wdata[0 +: WIDTH];
  assign sel_err   = (32'(sel_addr) >= DEPTH);

  // Final ACTIVE cycle: read data is sampled and the response is launched.
  assign last_active = (state_q == StActive) && (cnt_q == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      last_grant_q   <= 1'b1;
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      id_q           <= 1'b0;
      err_q          <= 1'b0;
      cell_cs_q      <= '0;
      cell_rd_wr_q   <= 1'b1;
      cell_wr_data_q <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= 1'b0;
      rsp_rdata_q    <= '0;
      rsp_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      last_grant_q   <= last_grant_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      id_q           <= id_d;
      err_q          <= err_d;
      cell_cs_q      <= cell_cs_d;
      cell_rd_wr_q   <= cell_rd_wr_d;
      cell_wr_data_q <= cell_wr_data_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_id_q       <= rsp_id_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_err_q      <= rsp_err_d;
    end
  end

  // Next-state and request capture.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    id_d         = id_q;
    err_d        = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d      = StSetup;
          last_grant_d = sel;
          we_d         = sel_we;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          id_d         = sel;
          err_d        = sel_err;
        end
      end
      StSetup: begin
        state_d = StActive;
        cnt_d   = CW'(PULSE - 1);
      end
      StActive: begin
        if (cnt_q == '0) state_d = StHold;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StHold: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered outputs. rd_wr / wr_data change only on accept (entering
  // SETUP, cs low) and on leaving HOLD (cs low), never next to a cs edge.
  always_comb begin
    cell_rd_wr_d   = cell_rd_wr_q;
    cell_wr_data_d = cell_wr_data_q;
    if (accept) begin
      cell_rd_wr_d   = ~sel_we;
      cell_wr_data_d = sel_we ? sel_wdata : '0;
    end else if (state_q == StHold) begin
      cell_rd_wr_d   = 1'b1;
      cell_wr_data_d = '0;
    end

    cell_cs_d = '0;
    if ((state_d == StActive) && !err_q) begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        cell_cs_d[r] = (addr_q == AW'(r));
      end
    end

    rsp_valid_d = last_active;
    rsp_id_d    = rsp_id_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (last_active) begin
      rsp_id_d    = id_q;
      rsp_err_d   = err_q;
      rsp_rdata_d = (we_q || err_q) ? '0 : cell_rd_data;
    end
  end

  assign cell_cs      = cell_cs_q;
  assign cell_rd_wr   = cell_rd_wr_q;
  assign cell_wr_data = cell_wr_data_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;

endmodule

// File: doc/cell_array_ctrl.md
Name: cell_array_ctrl

Overview:
Access controller for a DEPTH x WIDTH array of single-bit SR-latch memory cells, each with cs / rd_wr / wr_data / rd_data pins.
- Arbitrates word read/write requests from two requesters using round-robin.
- Sequences the array with a setup / select / hold protocol, so the latches never see a spurious write while the address or data is changing.
- Returns a tagged response per access.
- Sits between the processor-side ports and the cell array.

Parameters:
WIDTH, 8, bits per word (cells per row)
DEPTH, 16, number of rows; need not be a power of two
AW, $clog2(DEPTH), address width (derived, not overridden)
PULSE, 2, cycles cs is held high per access; must be >=1

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  2  per-requester request valid (bit i = requester i)
req_ready  out  2  per-requester accept; at most one bit high
req_we  in  2  1 = write, 0 = read
req_addr  in  2*AW  row address; requester i at [i*AW +: AW]
req_wdata  in  2*WIDTH  write word; requester i at [i*WIDTH +: WIDTH]
rsp_valid  out  1  one-cycle pulse, access complete
rsp_id  out  1  requester that owns the response
rsp_rdata  out  WIDTH  read word (0 for writes)
rsp_err  out  1  address >= DEPTH; no cell touched
cell_cs  out  DEPTH  one-hot row select, to every cell cs in the row
cell_rd_wr  out  1  shared rd_wr to all cells (1 = read)
cell_wr_data  out  WIDTH  shared column write data
cell_rd_data  in  WIDTH  column read data, OR of all rows (unselected cells drive 0)

Behaviour:
- Reset (rst=1 at edge): state IDLE, cell_cs=0, cell_rd_wr=1, cell_wr_data=0, rsp_valid=0, rsp_id=0, rsp_rdata=0, rsp_err=0, last_grant=1 (so requester 0 wins first contention). Reset mid-access aborts at the next edge: cs drops, no response is issued, and the cell keeps whatever it latched.
- All cell_* outputs and rsp_* are registered. req_ready is combinational: nonzero only in IDLE, equal to the arbiter grant.
- Arbitration (IDLE only): if only one valid, grant it. If both are valid, grant the requester != last_grant. last_grant updates on accept only.
- Handshake: an accept is valid & ready. A requester may not withdraw valid or change fields while unaccepted; the controller does not check this.
- FSM: IDLE -> SETUP -> ACTIVE(PULSE cycles, counter) -> HOLD -> IDLE.
  - Accept at edge T latches we/addr/wdata/id.
  - SETUP (cycle T+1): cell_rd_wr=~we, cell_wr_data=wdata (0 for reads), cell_cs=0.
  - ACTIVE (T+2..T+1+PULSE): cell_cs one-hot at addr, rd_wr and data held stable.
  - HOLD (T+2+PULSE): cell_cs=0, rd_wr/data still held. rsp_valid=1 with rsp_rdata captured from cell_rd_data at the last ACTIVE edge (reads only), plus rsp_id and rsp_err.
  - Return to IDLE: cell_rd_wr=1, cell_wr_data=0.
- Throughput: one access per PULSE+3 cycles. A new accept is possible in the IDLE cycle right after HOLD.
- Invariant: cell_rd_wr and cell_wr_data never change in a cycle where any cell_cs bit is or was high on the same edge. cell_rd_wr=0 only from SETUP through HOLD of a write.
- addr >= DEPTH: full sequence still runs (fixed latency), cell_cs stays 0, rsp_err=1, rsp_rdata=0.
- Reads: rsp_rdata is the selected row only. Other rows are gated off by their cs=0.

Decomposition:
- Package cell_array_pkg: state enum (IDLE, SETUP, ACTIVE, HOLD), NUM_REQ=2 constant, requester index constants.
- Sub-module rr_arb2: 2-way round-robin arbiter. Inputs req[1:0], last_grant, enable; output grant[1:0] one-hot.
- PULSE counter, address decode and response registers stay in cell_array_ctrl.

Test Plan:
- Reset then write req0 addr=3 wdata=0xA5, PULSE=2 -> req_ready[0] high in cycle 0; cell_cs=0x0008 in cycles 2-3 only; cell_rd_wr=0 cycles 1-4; rsp_valid in cycle 4, rsp_id=0, rsp_err=0.
- Read req1 addr=3 after that write (array model of SR latches) -> rsp_rdata=0xA5, rsp_id=1, cell_rd_wr=1 throughout.
- Both valid continuously, distinct addrs -> grants alternate 0,1,0,1 starting with 0; each accept 5 cycles apart; never two ready bits high.
- DEPTH=12, read addr=13 -> cell_cs=0 all cycles, rsp_err=1, rsp_rdata=0, same latency as a legal access.
- Assert rst during ACTIVE of a write -> next cycle cell_cs=0, cell_rd_wr=1, no rsp_valid; a subsequent req0 wins arbitration.
- Protocol checker over random traffic -> cell_rd_wr/cell_wr_data stable whenever |cell_cs; cell_cs one-hot or zero; every accept yields exactly one rsp_valid with matching id.
